// File: rtl/itof_pkg.sv
// itof_pkg: single-precision field constants and rounding-mode encoding for the itof pipeline.
package itof_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;
    typedef enum logic {RND_RNE = 1'b0, RND_TRUNC = 1'b1} rnd_e;
endpackage

// File: rtl/itof_pipe_if.sv
// itof_pipe_if: input operand and output result handshakes of the itof pipeline.
interface itof_pipe_if #(parameter int IN_W = 32);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_signed;
    logic            rnd_mode;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_inexact;
    modport master (output in_valid, in_data, in_signed, rnd_mode, out_ready,
                    input in_ready, out_valid, out_data, out_inexact);
    modport slave  (input in_valid, in_data, in_signed, rnd_mode, out_ready,
                    output in_ready, out_valid, out_data, out_inexact);
endinterface

// File: rtl/itof_lzc.sv
// itof_lzc: combinational leading-zero counter; an all-zero input returns W.
module itof_lzc #(
    parameter int W = 32,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a_i,
    output logic [CW-1:0] cnt_o
);
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++)
            if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage integer to IEEE-754 single converter (sign/magnitude, normalise, round/pack).
// Define ITOF_PIPE_TRUNC_EN to honour rnd_mode; otherwise round-to-nearest-even is always used.
module itof_pipe
    import itof_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter bit SIGNED_DEF = 1'b1
) (
    input logic         clk,
    input logic         rstn,
    itof_pipe_if.slave  bus
);
    localparam int LZ_W  = $clog2(IN_W + 1);
    localparam int EXT_W = IN_W + FP_MAN_W + 1;
    logic                s1_v_q, s2_v_q, out_v_q, mode_q, sgn_mode;
    logic                s1_sgn_q, s2_sgn_q, s1_sgn_d;
    logic [IN_W-1:0]     s1_mag_q, s1_mag_d, s2_norm_q, s2_norm_d;
    logic [FP_EXP_W-1:0] s2_exp_q, s2_exp_d, exp_r;
    logic [LZ_W-1:0]     lz;
    logic [31:0]         out_data_q, out_data_d;
    logic                out_inx_q, out_inx_d;
    logic                ld1, ld2, ld3, trunc, grd, stk, inc;
    logic [EXT_W-1:0]    ext;
    logic [FP_MAN_W-1:0] man;
    logic [FP_MAN_W:0]   man_r;
    assign ld3 = !out_v_q || bus.out_ready;
    assign ld2 = !s2_v_q || ld3;
    assign ld1 = !s1_v_q || ld2;
    assign bus.in_ready    = ld1;
    assign bus.out_valid   = out_v_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_inexact = out_inx_q;
    assign sgn_mode = bus.in_valid ? bus.in_signed : mode_q;
    assign s1_sgn_d = sgn_mode && bus.in_data[IN_W-1];
    assign s1_mag_d = s1_sgn_d ? -bus.in_data : bus.in_data;
    itof_lzc #(.W(IN_W)) u_lzc (.a_i(s1_mag_q), .cnt_o(lz));
    assign s2_norm_d = s1_mag_q << lz;
    assign s2_exp_d  = FP_EXP_W'(FP_BIAS + IN_W - 1) - FP_EXP_W'(lz);
`ifdef ITOF_PIPE_TRUNC_EN
    logic s1_rnd_q, s2_rnd_q;
    always_ff @(posedge clk) begin
        if (ld1) s1_rnd_q <= bus.rnd_mode;
        if (ld2) s2_rnd_q <= s1_rnd_q;
    end
    assign trunc = rnd_e'(s2_rnd_q) == RND_TRUNC;
`else
    logic unused_rnd;
    assign unused_rnd = bus.rnd_mode;
    assign trunc = 1'b0;
`endif
    // Leading one is implicit; a clear top bit after normalising means the operand was zero.
    always_comb begin
        ext        = {s2_norm_q[IN_W-2:0], (FP_MAN_W + 2)'(0)};
        man        = ext[EXT_W-1 -: FP_MAN_W];
        grd        = ext[EXT_W-1-FP_MAN_W];
        stk        = |ext[EXT_W-2-FP_MAN_W:0];
        inc        = !trunc && grd && (stk || man[0]);
        man_r      = {1'b0, man} + (FP_MAN_W + 1)'(inc);
        exp_r      = s2_exp_q + FP_EXP_W'(man_r[FP_MAN_W]);
        out_data_d = s2_norm_q[IN_W-1] ? {s2_sgn_q, exp_r, man_r[FP_MAN_W-1:0]} : '0;
        out_inx_d  = grd | stk;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_inx_q  <= 1'b0;
            mode_q     <= SIGNED_DEF;
        end else begin
            if (ld1) begin
                s1_v_q   <= bus.in_valid;
                s1_sgn_q <= s1_sgn_d;
                s1_mag_q <= s1_mag_d;
            end
            if (ld1 && bus.in_valid) mode_q <= bus.in_signed;
            if (ld2) begin
                s2_v_q    <= s1_v_q;
                s2_sgn_q  <= s1_sgn_q;
                s2_norm_q <= s2_norm_d;
                s2_exp_q  <= s2_exp_d;
            end
            if (ld3) begin
                out_v_q    <= s2_v_q;
                out_data_q <= out_data_d;
                out_inx_q  <= out_inx_d;
            end
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed and streaming checks of itof_pipe against an arithmetic reference model.
module tb_itof_pipe;
`ifdef ITOF_PIPE_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
    localparam logic [31:0] T_A = 32'h4B800001, T_B = 32'h4EFFFFFF;
`else
    localparam bit TRUNC_EN = 1'b0;
    localparam logic [31:0] T_A = 32'h4B800002, T_B = 32'h4F000000;
`endif
    typedef struct {logic [32:0] exp; int cyc;} item_t;
    typedef struct {logic [31:0] v; bit sg; bit rm; logic [32:0] exp;} vec_t;
    logic clk = 1'b0, rstn = 1'b0;
    int cyc = 0, n_chk = 0, n_fail = 0, bp_acc = 0;
    bit lat_chk = 0, bp_chk = 0, bp_seen = 0, hold = 0, done_r = 0;
    logic [32:0] held;
    item_t it;
    item_t sb[$];
    vec_t vec[13];

    itof_pipe_if #(.IN_W(32)) ifc ();
    itof_pipe #(.IN_W(32), .SIGNED_DEF(1'b1)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact magnitude, divide down to 24 significant bits, round on the remainder.
    function automatic logic [32:0] model(input logic [31:0] v, input bit sg, input bit tr);
        bit neg;
        longint unsigned m, q, rem, half;
        int p, e, s;
        neg = sg && v[31];
        m = neg ? 64'h1_0000_0000 - 64'(v) : 64'(v);
        if (m == 0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        e = 127 + p;
        rem = 0;
        if (p <= 23) q = m << (23 - p);
        else begin
            s = p - 23;
            q = m >> s;
            rem = m - (q << s);
            half = 64'd1 << (s - 1);
            if (!tr && (rem > half || (rem == half && q[0]))) q++;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
        end
        return {rem != 0, neg, 8'(e), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic send(input logic [31:0] v, input bit sg, input bit rm);
        int n = 0;
        ifc.in_valid = 1'b1; ifc.in_data = v; ifc.in_signed = sg; ifc.rnd_mode = rm;
        do begin @(negedge clk); n++; end while (!(ifc.in_ready && rstn) && n < 200);
        if (n >= 200) timeout("accept");
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) timeout("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            hold = 0;
        end else begin
            if (hold) begin
                check("hold_valid", 33'(ifc.out_valid), 33'd1);
                check("hold_data", {ifc.out_inexact, ifc.out_data}, held);
            end
            if (ifc.out_valid) begin
                if (sb.size() == 0) check("stale_result", 33'(ifc.out_valid), 33'd0);
                else if (ifc.out_ready) begin
                    it = sb.pop_front();
                    check("result", {ifc.out_inexact, ifc.out_data}, it.exp);
                    if (lat_chk) check("latency", 33'(cyc - it.cyc), 33'd3);
                end
            end
            hold = ifc.out_valid && !ifc.out_ready;
            held = {ifc.out_inexact, ifc.out_data};
            if (!bp_chk) begin
                bp_acc = 0;
                bp_seen = 0;
            end else if (ifc.in_valid && !ifc.in_ready && !bp_seen) begin
                check("bp_accepts_before_stall", 33'(bp_acc), 33'd3);
                bp_seen = 1;
            end
            if (ifc.in_valid && ifc.in_ready) begin
                sb.push_back('{model(ifc.in_data, ifc.in_signed, ifc.rnd_mode && TRUNC_EN), cyc});
                if (bp_chk) bp_acc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{32'h00000000, 1'b1, 1'b0, {1'b0, 32'h00000000}};
        vec[1]  = '{32'h00000001, 1'b1, 1'b0, {1'b0, 32'h3F800000}};
        vec[2]  = '{32'hFFFFFFFF, 1'b1, 1'b0, {1'b0, 32'hBF800000}};
        vec[3]  = '{32'h80000000, 1'b1, 1'b0, {1'b0, 32'hCF000000}};
        vec[4]  = '{32'h01000003, 1'b1, 1'b0, {1'b1, 32'h4B800002}};
        vec[5]  = '{32'h01000003, 1'b1, 1'b1, {1'b1, T_A}};
        vec[6]  = '{32'h7FFFFFFF, 1'b1, 1'b0, {1'b1, 32'h4F000000}};
        vec[7]  = '{32'h7FFFFFFF, 1'b1, 1'b1, {1'b1, T_B}};
        vec[8]  = '{32'hFFFFFFFF, 1'b0, 1'b0, {1'b1, 32'h4F800000}};
        vec[9]  = '{32'h00FFFFFF, 1'b0, 1'b0, {1'b0, 32'h4B7FFFFF}};
        vec[10] = '{32'h01000001, 1'b0, 1'b0, {1'b1, 32'h4B800000}};
        vec[11] = '{32'h00000000, 1'b0, 1'b0, {1'b0, 32'h00000000}};
        vec[12] = '{32'h80000000, 1'b0, 1'b0, {1'b0, 32'h4F000000}};
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_signed = 1'b0; ifc.rnd_mode = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 33'(ifc.out_valid), 33'd0);
        check("reset_out_data", 33'(ifc.out_data), 33'd0);
        check("reset_out_inexact", 33'(ifc.out_inexact), 33'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 33'(ifc.in_ready), 33'd1);
        @(posedge clk); #1;
        lat_chk = 1;
        foreach (vec[i]) begin
            check("model_pin", model(vec[i].v, vec[i].sg, vec[i].rm && TRUNC_EN), vec[i].exp);
            send(vec[i].v, vec[i].sg, vec[i].rm);
        end
        drain();
        for (int i = 0; i < 8; i++) send($urandom, 1'($urandom), 1'($urandom));
        drain();
        lat_chk = 0;
        ifc.out_ready = 1'b0;
        bp_chk = 1;
        fork
            begin
                for (int i = 0; i < 5; i++) send(32'h00123457 * (i + 1), 1'b1, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 ifc.out_ready = 1'b1;
            end
        join
        check("bp_stall_seen", 33'(bp_seen), 33'd1);
        bp_chk = 0;
        drain();
        done_r = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) send($urandom, 1'($urandom), 1'($urandom));
                done_r = 1;
            end
            begin
                while (!done_r) begin
                    @(posedge clk);
                    #1 ifc.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ifc.out_ready = 1'b1;
        drain();
        for (int i = 0; i < 3; i++) send(32'h0ABCDEF1 + i, 1'b0, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 33'(ifc.out_valid), 33'd0);
        check("flush_in_ready", 33'(ifc.in_ready), 33'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        send(32'hFFFFFF85, 1'b1, 1'b0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
